pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch front end. It replaces the free-running, always-enabled PC register with one that supports:
- a valid/ready handshake towards IF;
- a stall input;
- N prioritised redirect channels (trap, branch, jump, and so on);
- a fault state for misaligned redirect targets;
- a count of issued fetches.

It sits at the head of the pipeline and feeds the instruction-fetch stage.

---
 rtl/pc_gen_pkg.sv | 13 +
 rtl/pc_gen_if.sv | 24 ++
 rtl/pc_gen_redir_arb.sv | 30 +++
 rtl/pc_gen.sv | 91 +++++++++
 tb/tb_pc_gen.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-front-end PC generator.
// FSM encodings and reset defaults live here so every file agrees.
package pc_gen_pkg;

   localparam int unsigned REG_WIDTH     = 32;
   localparam logic [31:0] PC_RST        = 32'h8000_0000;
   localparam int unsigned PC_ALIGN_BITS = 2;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator and the IF stage.
// The master offers pc/npc with valid; the slave answers with ready.
interface pc_gen_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] npc;

   modport master (
      output valid,
      output pc,
      output npc,
      input  ready
   );

   modport slave (
      input  valid,
      input  pc,
      input  npc,
      output ready
   );
endinterface

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect picker: channel 0 wins.
// Also flags whether the chosen target violates alignment.
module pc_gen_redir_arb #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_REDIR  = 3,
   parameter int unsigned ALIGN_BITS = 2
) (
   input  logic [NUM_REDIR-1:0]      redir_valid,
   input  logic [NUM_REDIR*XLEN-1:0] redir_target,
   output logic                      any_valid,
   output logic [XLEN-1:0]           sel_target,
   output logic                      sel_misalign
);

   localparam logic [XLEN-1:0] AlignMask =
      XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

   // scan high to low so the lowest asserted index is left standing
   always_comb begin
      any_valid  = |redir_valid;
      sel_target = '0;
      for (int i = NUM_REDIR - 1; i >= 0; i--) begin
         if (redir_valid[i]) begin
            sel_target = redir_target[i*XLEN +: XLEN];
         end
      end
      sel_misalign = |(sel_target & AlignMask);
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch pipeline.
// BOOT/RUN/FAULT FSM, prioritised redirects, fetch counter.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN       = REG_WIDTH,
   parameter logic [XLEN-1:0] RESET_VAL  = PC_RST,
   parameter int unsigned     NUM_REDIR  = 3,
   parameter int unsigned     ALIGN_BITS = PC_ALIGN_BITS,
   parameter int unsigned     CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic [NUM_REDIR-1:0]      redir_valid,
   input  logic [NUM_REDIR*XLEN-1:0] redir_target,
   pc_gen_if.master                  fetch,
   output logic                      misalign_err,
   output logic [XLEN-1:0]           err_pc,
   output logic [CNT_W-1:0]          fetch_cnt
);

   logic [1:0]      state;
   logic [XLEN-1:0] pc;
   logic            any_redir;
   logic [XLEN-1:0] sel_target;
   logic            sel_misalign;
   logic            fire;

   pc_gen_redir_arb #(
      .XLEN       (XLEN),
      .NUM_REDIR  (NUM_REDIR),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_arb (
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .any_valid    (any_redir),
      .sel_target   (sel_target),
      .sel_misalign (sel_misalign)
   );

   // offer only in RUN with no stall and no redirect pending
   always_comb begin
      fetch.valid  = (state == ST_RUN) && !stall && !any_redir;
      fetch.pc     = pc;
      fetch.npc    = pc + XLEN'(4);
      misalign_err = (state == ST_FAULT);
      fire         = fetch.valid && fetch.ready;
   end

   // FSM, pc and captured fault target
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_BOOT;
         pc     <= RESET_VAL;
         err_pc <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN, ST_FAULT: begin
               if (any_redir) begin
                  if (sel_misalign) begin
                     err_pc <= sel_target;
                     state  <= ST_FAULT;
                  end else begin
                     pc    <= sel_target;
                     state <= ST_RUN;
                  end
               end else if (fire) begin
                  pc <= pc + XLEN'(4);
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   // count accepted handshakes, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
      end else if (fire) begin
         fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen.
// Expected outputs are queued on drive and popped on sample.
module tb_pc_gen;

   typedef struct {
      string       tag;
      logic        valid;
      logic [31:0] pc;
      logic        err;
      logic [31:0] err_pc;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [2:0]  redir_valid = '0;
   logic [95:0] redir_target = '0;
   logic        misalign_err;
   logic [31:0] err_pc;
   logic [3:0]  fetch_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   pc_gen_if #(.XLEN(32)) fetch_bus ();

   pc_gen #(
      .XLEN       (32),
      .RESET_VAL  (32'h8000_0000),
      .NUM_REDIR  (3),
      .ALIGN_BITS (2),
      .CNT_W      (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .fetch        (fetch_bus.master),
      .misalign_err (misalign_err),
      .err_pc       (err_pc),
      .fetch_cnt    (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // drive one cycle of inputs, queue the expectation, then sample
   task automatic cyc(input string tag, input logic r, input logic st,
                      input logic [2:0] rv, input logic [31:0] t0,
                      input logic [31:0] t1, input logic [31:0] t2,
                      input logic rdy, input logic e_valid,
                      input logic [31:0] e_pc, input logic e_err,
                      input logic [31:0] e_errpc, input logic [3:0] e_cnt);
      exp_t e;
      @(negedge clk);
      rst             = r;
      stall           = st;
      redir_valid     = rv;
      redir_target    = {t2, t1, t0};
      fetch_bus.ready = rdy;
      exp_q.push_back('{tag, e_valid, e_pc, e_err, e_errpc, e_cnt});
      #2;
      if (exp_q.size() == 0) begin
         check({tag, "_q"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, "_valid"}, 32'(fetch_bus.valid), 32'(e.valid));
         check({e.tag, "_pc"}, fetch_bus.pc, e.pc);
         check({e.tag, "_npc"}, fetch_bus.npc, e.pc + 32'd4);
         check({e.tag, "_err"}, 32'(misalign_err), 32'(e.err));
         check({e.tag, "_errpc"}, err_pc, e.err_pc);
         check({e.tag, "_cnt"}, 32'(fetch_cnt), 32'(e.cnt));
      end
   endtask

   localparam logic [31:0] B = 32'h8000_0000;

   initial begin
      fetch_bus.ready = 1'b1;
      @(negedge clk);
      // reset held: three cycles, last two checked
      cyc("rst1", 1, 0, 0, 0, 0, 0, 1, 0, B, 0, 0, 0);
      cyc("rst2", 1, 0, 0, 0, 0, 0, 1, 0, B, 0, 0, 0);
      // release: one BOOT cycle, then a PC per cycle
      cyc("boot", 0, 0, 0, 0, 0, 0, 1, 0, B, 0, 0, 0);
      cyc("f0", 0, 0, 0, 0, 0, 0, 1, 1, B, 0, 0, 0);
      cyc("f1", 0, 0, 0, 0, 0, 0, 1, 1, B + 4, 0, 0, 1);
      cyc("f2", 0, 0, 0, 0, 0, 0, 1, 1, B + 8, 0, 0, 2);
      cyc("f3", 0, 0, 0, 0, 0, 0, 1, 1, B + 12, 0, 0, 3);
      // backpressure at 80000010
      for (int i = 0; i < 4; i++)
         cyc("bp", 0, 0, 0, 0, 0, 0, 0, 1, B + 16, 0, 0, 4);
      cyc("bp_go", 0, 0, 0, 0, 0, 0, 1, 1, B + 16, 0, 0, 4);
      // redirect priority with stall
      cyc("rd_req", 0, 1, 3'b110, 0, B + 32'h1000, B + 32'h2000, 1,
          0, B + 20, 0, 0, 5);
      cyc("rd_go", 0, 0, 0, 0, 0, 0, 1, 1, B + 32'h1000, 0, 0, 5);
      // misaligned redirect enters FAULT
      cyc("mis_req", 0, 0, 3'b001, B + 32'h102, 0, 0, 1,
          0, B + 32'h1004, 0, 0, 6);
      cyc("flt", 0, 0, 0, 0, 0, 0, 1, 0, B + 32'h1004, 1, B + 32'h102, 6);
      cyc("flt_st", 0, 1, 0, 0, 0, 0, 1, 0, B + 32'h1004, 1,
          B + 32'h102, 6);
      cyc("flt_rd", 0, 0, 3'b100, 0, 0, B + 32'h200, 1,
          0, B + 32'h1004, 1, B + 32'h102, 6);
      cyc("run", 0, 0, 0, 0, 0, 0, 1, 1, B + 32'h200, 0, B + 32'h102, 6);
      // plain stall drops the offer and holds
      cyc("stall", 0, 1, 0, 0, 0, 0, 1, 0, B + 32'h204, 0, B + 32'h102, 7);
      cyc("hold", 0, 0, 0, 0, 0, 0, 0, 1, B + 32'h204, 0, B + 32'h102, 7);
      // run the counter up to 15
      for (int i = 0; i < 8; i++)
         cyc("cnt", 0, 0, 0, 0, 0, 0, 1, 1, B + 32'h204 + 32'(4 * i), 0,
             B + 32'h102, 4'(7 + i));
      // wrap of both pc and counter
      cyc("wr_req", 0, 0, 3'b001, 32'hFFFF_FFFC, 0, 0, 1,
          0, B + 32'h224, 0, B + 32'h102, 15);
      cyc("wr_fire", 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0,
          B + 32'h102, 15);
      cyc("wrapped", 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, B + 32'h102, 0);
      // reset in the middle of FAULT, with a redirect present
      cyc("mis2", 0, 0, 3'b001, 32'h3, 0, 0, 0, 0, 32'h0, 0,
          B + 32'h102, 0);
      cyc("flt2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h3, 0);
      cyc("rst_f", 1, 0, 3'b001, 32'h100, 0, 0, 1, 0, 32'h0, 1, 32'h3, 0);
      cyc("boot2", 0, 0, 0, 0, 0, 0, 1, 0, B, 0, 0, 0);
      cyc("f0b", 0, 0, 0, 0, 0, 0, 1, 1, B, 0, 0, 0);
      cyc("f1b", 0, 0, 0, 0, 0, 0, 1, 1, B + 4, 0, 0, 1);
      check("q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
